// File: rtl/country_vehicle_sensor.sv
// country_vehicle_sensor: debounced country-road loop detector that counts waiting cars
// and drives the controller request x, capping green time so the highway gets its turn back.
module country_vehicle_sensor #(
  parameter int DEBOUNCE  = 4,
  parameter int MAX_QUEUE = 7,
  parameter int QW        = 3,
  parameter int MAX_GREEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          loop_raw,
  input  logic [1:0]    country_road,
  output logic          x,
  output logic [QW-1:0] queue,
  output logic          overflow
);
  localparam int TW = $clog2(MAX_GREEN);
  typedef enum logic [1:0] {IDLE, REQUEST, SERVE, RELEASE} state_t;
  state_t state, nxt;
  logic s1, s2, loop_db, db_q;
  logic [7:0] db_cnt;
  logic [TW-1:0] timer;
  logic green, rise, fall, q_empty, q_full;
  assign green   = country_road == 2'b10;
  assign rise    = loop_db & ~db_q;
  assign fall    = ~loop_db & db_q & green;
  assign q_empty = queue == '0;
  assign q_full  = queue == QW'(MAX_QUEUE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      loop_db <= 1'b0;
      db_q    <= 1'b0;
      db_cnt  <= '0;
    end else begin
      s1   <= loop_raw;
      s2   <= s1;
      db_q <= loop_db;
      if (s2 == loop_db) db_cnt <= '0;
      else if (db_cnt == 8'(DEBOUNCE - 1)) begin
        loop_db <= s2;
        db_cnt  <= '0;
      end else db_cnt <= db_cnt + 8'd1;
    end
  end
  // rise and fall of loop_db never coincide, so inc and dec are exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      queue    <= '0;
      overflow <= 1'b0;
    end else if (rise) begin
      if (q_full) overflow <= 1'b1;
      else queue <= queue + QW'(1);
    end else if (fall && !q_empty) queue <= queue - QW'(1);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = q_empty ? IDLE : REQUEST;
      REQUEST: nxt = q_empty ? IDLE : green ? SERVE : REQUEST;
      SERVE:   nxt = !green ? (q_empty ? IDLE : REQUEST)
                          : (q_empty || timer == TW'(MAX_GREEN - 1)) ? RELEASE : SERVE;
      RELEASE: nxt = green ? RELEASE : q_empty ? IDLE : REQUEST;
      default: nxt = IDLE;
    endcase
  end
  // timer is zero on the first SERVE cycle because any other state clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= 1'b0;
      timer <= '0;
    end else begin
      state <= nxt;
      x     <= nxt == REQUEST || nxt == SERVE;
      timer <= state == SERVE ? timer + TW'(1) : '0;
    end
  end
endmodule

// File: doc/country_vehicle_sensor.md
# country_vehicle_sensor

Country-road vehicle detector that produces the `x` request consumed by the highway/country-road traffic controller and observes that controller's `country_road` light output to track service. It synchronizes and debounces a raw inductive-loop input, keeps a saturating count of waiting vehicles, and drives `x` through a four-state FSM. The FSM caps country-road green time, which guarantees the highway gets its turn back.

## Interface
- `DEBOUNCE`, default 4: consecutive stable cycles required before the debounced loop value changes; legal range 1..255.
- `MAX_QUEUE`, default 7: saturation value of the vehicle count; must fit in `QW` bits.
- `QW`, default 3: width of `queue`.
- `MAX_GREEN`, default 16: maximum cycles `x` is held while country road is green; legal range ≥ 2.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `loop_raw`  in  1  raw loop-detector level, asynchronous to `clk`; 1 means vehicle over loop.
- `country_road`  in  2  controller's country-road light: 00 red, 01 yellow, 10 green, 11 treated as red.
- `x`  out  1  registered request to the controller.
- `queue`  out  QW  registered waiting-vehicle count.
- `overflow`  out  1  sticky flag; set when an arrival occurs with `queue` == `MAX_QUEUE`.

## Operation
- Reset (async assert, sync release): sync flops 0, debounced `loop_db` = 0, debounce counter 0, `queue` = 0, `overflow` = 0, FSM = IDLE, green timer 0, `x` = 0.
- Synchronizer: two flops on `loop_raw` produce `s2`.
- Debounce: when `s2` ≠ `loop_db`, the counter increments. On the cycle the counter would reach `DEBOUNCE`, `loop_db` takes `s2` and the counter clears. When `s2` == `loop_db`, the counter clears. Glitches shorter than `DEBOUNCE` cycles are ignored.
- Arrival = rising edge of `loop_db`. It increments `queue`. At `MAX_QUEUE` the count holds and `overflow` sets. `overflow` clears only on reset.
- Departure = falling edge of `loop_db` while `country_road` == 10. It decrements `queue`. At 0 the count holds. A falling edge under any other light is ignored.
- Rising and falling edges are mutually exclusive, so there is no simultaneous inc/dec case.
- FSM states and transitions:
  - IDLE (`x`=0): go to REQUEST when `queue` ≠ 0.
  - REQUEST (`x`=1): go to SERVE when `country_road` == 10. If `queue` returns to 0 (not possible without green, kept for robustness), go to IDLE.
  - SERVE (`x`=1): the green timer counts up from 0 each cycle. Go to RELEASE when `queue` == 0 or the timer == `MAX_GREEN`-1. If `country_road` leaves green early, go to REQUEST when `queue` ≠ 0, otherwise IDLE.
  - RELEASE (`x`=0): wait for `country_road` ≠ 10, then go to REQUEST if `queue` ≠ 0, otherwise IDLE. Arrivals and departures still update `queue` in this state.
- The green timer clears on every entry to SERVE. Yellow counts as not green.
- `x` is a register decoded from the next state: 1 in REQUEST and SERVE.

## Timing
- Arrival latency: first edge sampling `loop_raw`=1 is edge 1. `loop_db` rises at edge `DEBOUNCE`+2, `queue` increments at edge `DEBOUNCE`+3, `x` rises at edge `DEBOUNCE`+4.
- Departure latency: the same count applies from `loop_raw` falling to the `queue` decrement (edge `DEBOUNCE`+3).
- `x` falls on the edge after `queue` reaches 0 in SERVE, or on edge `MAX_GREEN` after SERVE entry at the latest.
- `x` cannot re-assert until the light has left green for at least one sampled cycle.
- `rst_n` low mid-operation returns all outputs to reset values immediately, without waiting for `clk`.

## Test plan
- Single car, `DEBOUNCE`=4: `loop_raw` high 20 cycles, light red → `queue`=1 and `x`=1 at edge 8. Then light green and `loop_raw` low → `queue`=0 at edge 7 after the fall, `x`=0 one edge later.
- Glitch rejection: `loop_raw` pulses of 1, 2 and 3 cycles → `queue` stays 0, `x` stays 0.
- Green cap, `MAX_GREEN`=16: `queue`=3 with no departures, light held green → `x` falls exactly 16 edges after SERVE entry. Green→yellow → `x` re-asserts one edge after yellow is sampled.
- Saturation: 8 arrivals with light red, `MAX_QUEUE`=7 → `queue`=7 and `overflow`=1. Then 8 departures under green → `queue`=0 with no underflow, and `overflow` stays 1.
- Red-light departure ignored: arrival, then loop falls while `country_road`=00 → `queue` stays 1 and `x` stays 1.
- Async reset in SERVE with `queue`=2: drop `rst_n` between clock edges → `x`=0, `queue`=0, `overflow`=0 immediately; after release the FSM is in IDLE.
